// File: rtl/instructions.sv
// Shared core types: PC source select and the fetch sequencer state encoding.
package instructions;

  typedef enum logic {
    PC_INPUT_PC_PLUS_4 = 1'b0,
    PC_INPUT_ALU       = 1'b1
  } pc_input_sel_t;

  typedef enum logic [1:0] {
    ISSUE     = 2'd0,
    WAIT_RESP = 2'd1,
    HOLD      = 2'd2,
    DRAIN     = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_sequencer_pc_next_mux.sv
// Next-PC selection: sequential pc+4 or an aligned redirect target.
// With PC_MISALIGN_TRAP_EN a target with bit 1 set steers to TRAP_VECTOR and raises misalign.
module pc_next_mux
  import instructions::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] redirect_pc;

`ifdef PC_MISALIGN_TRAP_EN
  logic [31:0] target_half;
  logic        unused_target_bit;

  assign target_half       = {target[31:1], 1'b0};
  assign unused_target_bit = target[0];
  assign misalign          = redirect & target_half[1];
  assign redirect_pc       = target_half[1] ? TRAP_VECTOR : target_half;
`else
  logic [32:0] unused_cfg_bits;

  // Without the trap, low bits are simply dropped so fetch stays word aligned.
  assign unused_cfg_bits = {TRAP_VECTOR, target[1]} ^ {32'd0, target[0]};
  assign misalign        = 1'b0;
  assign redirect_pc     = {target[31:2], 2'b00};
`endif

  // 32-bit add wraps naturally: 32'hFFFF_FFFC + 4 = 0.
  assign next_pc = redirect ? redirect_pc : pc + PC_STEP;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC and runs one-outstanding instruction fetch to decode.
// Optional macro PC_MISALIGN_TRAP_EN adds the misaligned-redirect trap ports.
module fetch_sequencer
  import instructions::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect_valid,
  input  pc_input_sel_t pc_input_sel,
  input  logic [31:0]   alu_result,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [31:0]   imem_req_addr,
  input  logic          imem_resp_valid,
  input  logic [31:0]   imem_resp_data,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [31:0]   if_instr,
  output logic [31:0]   if_pc,
  output fetch_state_t  fsm_state
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic          trap_valid,
  output logic [31:0]   trap_addr
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Decode-side valid and its payload hold steady until that transfer, unless a redirect
  // squashes the word; imem request address may move while unaccepted.

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         pc_misalign;
  logic         taken;

  assign taken = redirect_valid && (pc_input_sel == PC_INPUT_ALU);

  pc_next_mux #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_pc_next_mux (
    .pc       (pc),
    .redirect (taken),
    .target   (alu_result),
    .next_pc  (next_pc),
    .misalign (pc_misalign)
  );

`ifndef PC_MISALIGN_TRAP_EN
  logic unused_misalign;
  assign unused_misalign = pc_misalign;
`endif

  assign imem_req_valid = (state == ISSUE) && !reset;
  assign imem_req_addr  = pc;
  assign fsm_state      = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      state    <= ISSUE;
      if_valid <= 1'b0;
      if_instr <= 32'd0;
      if_pc    <= 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_valid <= 1'b0;
      trap_addr  <= 32'd0;
`endif
    end else begin
`ifdef PC_MISALIGN_TRAP_EN
      trap_valid <= taken && pc_misalign;
      if (taken && pc_misalign) trap_addr <= {alu_result[31:1], 1'b0};
`endif
      // A taken redirect always wins over the pc+4 step and over decode consumption.
      case (state)
        ISSUE: begin
          if (taken) begin
            pc <= next_pc;
            if (imem_req_ready) state <= DRAIN;
          end else if (imem_req_ready) begin
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (taken) begin
            pc    <= next_pc;
            state <= imem_resp_valid ? ISSUE : DRAIN;
          end else if (imem_resp_valid) begin
            if_instr <= imem_resp_data;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= next_pc;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (taken) begin
            pc       <= next_pc;
            if_valid <= 1'b0;
            state    <= ISSUE;
          end else if (if_ready) begin
            if_valid <= 1'b0;
            state    <= ISSUE;
          end
        end
        DRAIN: begin
          if (taken) pc <= next_pc;
          if (imem_resp_valid) state <= ISSUE;
        end
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: imem model returning addr-as-data, budgeted decode consumer,
// and a scoreboard of expected fetch addresses.
module tb_fetch_sequencer;
  import instructions::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_valid = 1'b0;
  pc_input_sel_t pc_input_sel = PC_INPUT_PC_PLUS_4;
  logic [31:0]   alu_result = 32'd0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b1;
  logic [31:0]   imem_req_addr;
  logic          imem_resp_valid = 1'b0;
  logic [31:0]   imem_resp_data = 32'd0;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  fetch_state_t  fsm_state;
`ifdef PC_MISALIGN_TRAP_EN
  logic          trap_valid;
  logic [31:0]   trap_addr;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;
  logic [31:0] next_exp = 32'd0;
  int          consume_budget = 0;
  logic        force_ready = 1'b0;
  int          resp_delay = 0;
  logic        rand_delay = 1'b0;
  logic        pend = 1'b0;
  logic        armed = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  logic [31:0] armed_addr = 32'd0;
  int          pend_cnt = 0;

  fetch_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .pc_input_sel    (pc_input_sel),
    .alu_result      (alu_result),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .fsm_state       (fsm_state)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .trap_valid      (trap_valid),
    .trap_addr       (trap_addr)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // imem model and decode consumer, driven on the falling edge
  always @(negedge clk) begin
    imem_resp_valid = 1'b0;
    if_ready = (consume_budget > 0) || force_ready;
    if (reset) begin
      pend  = 1'b0;
      armed = 1'b0;
    end else begin
      if (armed) begin
        pend      = 1'b1;
        pend_addr = armed_addr;
        pend_cnt  = rand_delay ? int'($urandom_range(0, 3)) : resp_delay;
        armed     = 1'b0;
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = pend_addr;
          pend            = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (pend && imem_req_valid) begin
        checks++;
        errors++;
        $display("FAIL one_outstanding req_addr=%h while %h pending", imem_req_addr, pend_addr);
      end
      if (imem_req_valid && imem_req_ready) begin
        armed      = 1'b1;
        armed_addr = imem_req_addr;
      end
      // Scoreboard: a word squashed by a taken redirect is not a delivery.
      if (if_valid && if_ready && !(redirect_valid && pc_input_sel == PC_INPUT_ALU)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_fetch if_pc=%h if_instr=%h", if_pc, if_instr);
        end else begin
          exp_word = exp_q.pop_front();
          if (if_pc !== exp_word || if_instr !== exp_word) begin
            errors++;
            $display("FAIL fetch_word if_pc=%h if_instr=%h expected %h", if_pc, if_instr, exp_word);
          end
        end
        if (consume_budget > 0) consume_budget--;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input fetch_state_t s, input int max_cycles, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (fsm_state == s) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_wait state=%0d expected %0d", name, fsm_state, s);
    end
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (consume_budget == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain outstanding=%0d expected 0", name, exp_q.size());
      exp_q.delete();
      consume_budget = 0;
    end
  endtask

  task automatic consume(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 32'd4;
    end
    consume_budget = n;
  endtask

  task automatic pulse_redirect(input logic [31:0] target, input logic with_ready);
    redirect_valid = 1'b1;
    pc_input_sel   = PC_INPUT_ALU;
    alu_result     = target;
    force_ready    = with_ready;
    tick();
    redirect_valid = 1'b0;
    pc_input_sel   = PC_INPUT_PC_PLUS_4;
    force_ready    = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs if_valid=%b if_instr=%h if_pc=%h expected 0", if_valid, if_instr, if_pc);
    end
    checks++;
    if (fsm_state !== ISSUE) begin
      errors++;
      $display("FAIL reset_state state=%0d expected %0d", fsm_state, ISSUE);
    end
`ifdef PC_MISALIGN_TRAP_EN
    checks++;
    if (trap_valid !== 1'b0 || trap_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_trap trap_valid=%b trap_addr=%h expected 0", trap_valid, trap_addr);
    end
`endif
    next_exp = 32'd0;
    consume(3);
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd0) begin
      errors++;
      $display("FAIL first_request valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
    end
    tick();
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early if_valid=%b expected 0", if_valid);
    end
    tick();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd0) begin
      errors++;
      $display("FAIL latency_two if_valid=%b if_pc=%h expected 1/00000000", if_valid, if_pc);
    end
    wait_drain(60, "reset_seq");
  endtask

  task automatic test_hold_stall();
    wait_state(HOLD, 20, "hold");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (if_valid !== 1'b1 || if_pc !== next_exp || if_instr !== next_exp || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cycle=%0d if_valid=%b if_pc=%h if_instr=%h req=%b expected 1/%h/%h/0",
                 i, if_valid, if_pc, if_instr, imem_req_valid, next_exp, next_exp);
      end
      tick();
    end
    consume(1);
    wait_drain(30, "hold");
  endtask

  task automatic test_redirect_wait_resp();
    resp_delay = 2;
    consume(1);
    wait_drain(30, "jal_pre");
    wait_state(WAIT_RESP, 20, "jal");
    pulse_redirect(32'h0000_0200, 1'b0);
    checks++;
    if (fsm_state !== DRAIN || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL jal_drain state=%0d req=%b expected %0d/0", fsm_state, imem_req_valid, DRAIN);
    end
    resp_delay = 0;
    wait_state(ISSUE, 10, "jal_issue");
    checks++;
    if (imem_req_addr !== 32'h0000_0200) begin
      errors++;
      $display("FAIL jal_addr addr=%h expected 00000200", imem_req_addr);
    end
    next_exp = 32'h0000_0200;
    consume(1);
    wait_drain(30, "jal");
  endtask

  task automatic test_redirect_hold_ready();
    wait_state(HOLD, 20, "hold_redir");
    pulse_redirect(32'h0000_0400, 1'b1);
    checks++;
    if (if_valid !== 1'b0 || fsm_state !== ISSUE || imem_req_addr !== 32'h0000_0400) begin
      errors++;
      $display("FAIL hold_redirect if_valid=%b state=%0d addr=%h expected 0/%0d/00000400",
               if_valid, fsm_state, imem_req_addr, ISSUE);
    end
    next_exp = 32'h0000_0400;
    consume(1);
    wait_drain(30, "hold_redir");
  endtask

  task automatic test_not_taken();
    wait_state(HOLD, 20, "not_taken");
    redirect_valid = 1'b1;
    pc_input_sel   = PC_INPUT_PC_PLUS_4;
    alu_result     = 32'h0000_0800;
    consume(3);
    wait_drain(40, "not_taken");
    redirect_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    logic [31:0] exp_addr;
    wait_state(HOLD, 20, "misalign");
    pulse_redirect(32'h0000_0302, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
    exp_addr = 32'h0000_0100;
    checks++;
    if (trap_valid !== 1'b1 || trap_addr !== 32'h0000_0302) begin
      errors++;
      $display("FAIL trap_pulse trap_valid=%b trap_addr=%h expected 1/00000302", trap_valid, trap_addr);
    end
`else
    exp_addr = 32'h0000_0300;
`endif
    checks++;
    if (imem_req_addr !== exp_addr || fsm_state !== ISSUE) begin
      errors++;
      $display("FAIL misalign_addr addr=%h state=%0d expected %h/%0d", imem_req_addr, fsm_state, exp_addr, ISSUE);
    end
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    checks++;
    if (trap_valid !== 1'b0) begin
      errors++;
      $display("FAIL trap_single trap_valid=%b expected 0", trap_valid);
    end
`endif
    next_exp = exp_addr;
    consume(1);
    wait_drain(30, "misalign");
  endtask

  task automatic test_wrap();
    wait_state(HOLD, 20, "wrap");
    pulse_redirect(32'hFFFF_FFFC, 1'b0);
    checks++;
    if (imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_target addr=%h expected fffffffc", imem_req_addr);
    end
    next_exp = 32'hFFFF_FFFC;
    consume(2);
    wait_drain(40, "wrap");
  endtask

  task automatic test_back_to_back();
    int n;
    rand_delay = 1'b1;
    n = int'($urandom_range(6, 10));
    consume(n);
    wait_drain(200, "back_to_back");
    rand_delay = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold_stall();
    test_redirect_wait_resp();
    test_redirect_hold_ready();
    test_not_taken();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
